// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared motion-estimation geometry and slice offset helper
package me_pkg;

  localparam int PIXELS_IN_BATCH = 16;
  localparam int EDGE_LEN        = 8;
  localparam int BIT_DEPTH       = 8;
  localparam int ROW_PIX         = PIXELS_IN_BATCH + EDGE_LEN - 1;

  // LSB of lane m in slice k within the flattened slice bus
  function automatic int slice_lsb(input int k, input int m,
                                   input int pib = PIXELS_IN_BATCH,
                                   input int bd  = BIT_DEPTH);
    return (k * pib + m) * bd;
  endfunction

endpackage

// File: rtl/row_slicer.sv
// rtl/row_slicer.sv - splits one row into EL overlapping PIB-pixel slices
module row_slicer
  import me_pkg::*;
#(
  parameter int PIB = me_pkg::PIXELS_IN_BATCH,
  parameter int EL  = me_pkg::EDGE_LEN,
  parameter int BD  = me_pkg::BIT_DEPTH
) (
  input  logic [(PIB+EL-1)*BD-1:0] row_i,
  output logic [EL*PIB*BD-1:0]     slices_o
);

  for (genvar k = 0; k < EL; k++) begin : g_slice
    for (genvar m = 0; m < PIB; m++) begin : g_lane
      assign slices_o[slice_lsb(k, m, PIB, BD) +: BD] = row_i[(k+m)*BD +: BD];
    end
  end

endmodule

// File: rtl/ref_window_buffer.sv
// rtl/ref_window_buffer.sv - circular search-window row buffer with mark/rewind replay
module ref_window_buffer
  import me_pkg::*;
#(
  parameter int PIXELS_IN_BATCH = me_pkg::PIXELS_IN_BATCH,
  parameter int EDGE_LEN        = me_pkg::EDGE_LEN,
  parameter int BIT_DEPTH       = me_pkg::BIT_DEPTH,
  parameter int DEPTH           = 16,
  localparam int ROW_PIX        = PIXELS_IN_BATCH + EDGE_LEN - 1,
  localparam int PW             = $clog2(DEPTH) + 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [ROW_PIX*BIT_DEPTH-1:0]               data_in,
  input  logic                                       in_valid_i,
  output logic                                       in_ready_o,
  output logic [EDGE_LEN*PIXELS_IN_BATCH*BIT_DEPTH-1:0] reference_input_column,
  output logic                                       out_valid_o,
  input  logic                                       out_ready_i,
  input  logic                                       flush_i,
  input  logic                                       mark_i,
  input  logic                                       rewind_i,
  output logic [PW-1:0]                              level_o
);

  localparam int AW    = PW - 1;
  localparam int ROW_W = ROW_PIX * BIT_DEPTH;
  localparam int COL_W = EDGE_LEN * PIXELS_IN_BATCH * BIT_DEPTH;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    mark_ptr_q, mark_ptr_d;
  logic             marked_q, marked_d;
  logic [ROW_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]    base;
  logic             full, empty, push, pop;
  logic [ROW_W-1:0] head_row;
  logic [COL_W-1:0] slices;

  // While marked, rows from the mark onward must survive for replay
  always_comb begin
    base  = marked_q ? mark_ptr_q : rd_ptr_q;
    full  = ((wr_ptr_q - base) == PW'(DEPTH));
    empty = (wr_ptr_q == rd_ptr_q);
    push  = in_valid_i && !full;
    pop   = out_ready_i && !empty;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mark_ptr_d = mark_ptr_q;
    marked_d   = marked_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mark_ptr_d = '0;
      marked_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rewind_i && marked_q) begin
        rd_ptr_d = mark_ptr_q;
      end else begin
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (mark_i) begin
          mark_ptr_d = rd_ptr_q;
          marked_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mark_ptr_q <= '0;
      marked_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mark_ptr_q <= mark_ptr_d;
      marked_q   <= marked_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  assign head_row = mem_q[rd_ptr_q[AW-1:0]];

  row_slicer #(
    .PIB (PIXELS_IN_BATCH),
    .EL  (EDGE_LEN),
    .BD  (BIT_DEPTH)
  ) u_row_slicer (
    .row_i    (head_row),
    .slices_o (slices)
  );

  assign in_ready_o             = !full;
  assign out_valid_o            = !empty;
  assign level_o                = wr_ptr_q - rd_ptr_q;
  assign reference_input_column = empty ? '0 : slices;

endmodule

// File: tb/tb_ref_window_buffer.sv
// tb/tb_ref_window_buffer.sv - table, directed and random checks against a queue model
module tb_ref_window_buffer;
  import me_pkg::*;

  localparam int PIB   = 16;
  localparam int EL    = 8;
  localparam int BD    = 8;
  localparam int DEPTH = 16;
  localparam int RP    = PIB + EL - 1;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int ROW_W = RP * BD;
  localparam int COL_W = EL * PIB * BD;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [ROW_W-1:0] data_in;
  logic             in_valid_i, out_ready_i, flush_i, mark_i, rewind_i;
  logic             in_ready_o, out_valid_o;
  logic [COL_W-1:0] reference_input_column;
  logic [PW-1:0]    level_o;

  ref_window_buffer #(
    .PIXELS_IN_BATCH (PIB),
    .EDGE_LEN        (EL),
    .BIT_DEPTH       (BD),
    .DEPTH           (DEPTH)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .data_in                (data_in),
    .in_valid_i             (in_valid_i),
    .in_ready_o             (in_ready_o),
    .reference_input_column (reference_input_column),
    .out_valid_o            (out_valid_o),
    .out_ready_i            (out_ready_i),
    .flush_i                (flush_i),
    .mark_i                 (mark_i),
    .rewind_i               (rewind_i),
    .level_o                (level_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: rows kept from the protection base onward; head sits at rd_off
  logic [ROW_W-1:0] mq[$];
  int               rd_off = 0;
  bit               mmarked = 0;

  typedef struct {
    bit in_valid, out_ready, flush, mark, rewind;
    int exp_level;
    bit exp_valid, exp_ready;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(bit iv, bit orr, bit fl, bit mk_, bit rw, int lv, bit vv, bit rr);
    vec_t v;
    v.in_valid = iv; v.out_ready = orr; v.flush = fl; v.mark = mk_; v.rewind = rw;
    v.exp_level = lv; v.exp_valid = vv; v.exp_ready = rr;
    return v;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row(input logic [7:0] id);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W; i += 32) r[i +: 32] = $urandom;
    r[7:0] = id;
    return r;
  endfunction

  function automatic logic [COL_W-1:0] slices_of(input logic [ROW_W-1:0] r);
    logic [COL_W-1:0] c;
    for (int k = 0; k < EL; k++)
      for (int m = 0; m < PIB; m++)
        c[(k*PIB + m)*BD +: BD] = r[(k + m)*BD +: BD];
    return c;
  endfunction

  task automatic model_reset();
    mq.delete();
    rd_off  = 0;
    mmarked = 0;
  endtask

  task automatic model_step();
    bit full, empty, push, pop;
    full  = (mq.size() == DEPTH);
    empty = (rd_off == mq.size());
    push  = in_valid_i && !full;
    pop   = out_ready_i && !empty;
    if (flush_i) begin
      model_reset();
    end else begin
      if (rewind_i && mmarked) begin
        rd_off = 0;
      end else begin
        if (mark_i) begin
          for (int i = 0; i < rd_off; i++) mq.delete(0);
          rd_off  = 0;
          mmarked = 1;
        end
        if (pop) begin
          if (mmarked) rd_off++;
          else mq.delete(0);
        end
      end
      if (push) mq.push_back(data_in);
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_col(input string name, input logic [COL_W-1:0] act, input logic [COL_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < COL_W/8; i++)
        if (act[i*8 +: 8] !== exp[i*8 +: 8]) begin
          $display("FAIL %s: column byte %0d got %02h expected %02h", name, i, act[i*8 +: 8], exp[i*8 +: 8]);
          break;
        end
    end
  endtask

  task automatic check_model(input string tag);
    bit m_empty;
    m_empty = (rd_off == mq.size());
    chk({tag, "_valid"}, out_valid_o, !m_empty);
    chk({tag, "_ready"}, in_ready_o, mq.size() != DEPTH);
    chk({tag, "_level"}, level_o, mq.size() - rd_off);
    chk_col({tag, "_column"}, reference_input_column, m_empty ? '0 : slices_of(mq[rd_off]));
  endtask

  task automatic set_in(bit iv, bit orr, bit fl, bit mk_, bit rw, logic [ROW_W-1:0] row);
    in_valid_i = iv; out_ready_i = orr; flush_i = fl; mark_i = mk_; rewind_i = rw; data_in = row;
  endtask

  task automatic tick(input string tag);
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_model(tag);
  endtask

  initial begin
    logic [ROW_W-1:0] ramp;
    logic [PIB*BD-1:0] exp_slice;

    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0, '0);
    @(negedge clk_i);
    check_model("reset");
    chk_col("reset_column_zero", reference_input_column, '0);
    rst_i = 1'b0;

    // Table-driven sequence of handshake/control patterns
    tbl[0]  = mk(1,0,0,0,0, 1,1,1);
    tbl[1]  = mk(1,1,0,0,0, 1,1,1);
    tbl[2]  = mk(0,0,0,0,0, 1,1,1);
    tbl[3]  = mk(0,1,0,0,0, 0,0,1);
    tbl[4]  = mk(1,0,0,0,0, 1,1,1);
    tbl[5]  = mk(1,0,0,0,0, 2,1,1);
    tbl[6]  = mk(1,0,0,0,0, 3,1,1);
    tbl[7]  = mk(0,1,0,1,0, 2,1,1);
    tbl[8]  = mk(0,1,0,0,0, 1,1,1);
    tbl[9]  = mk(0,1,0,0,1, 3,1,1);
    tbl[10] = mk(0,0,0,1,1, 3,1,1);
    tbl[11] = mk(0,1,0,1,0, 2,1,1);
    tbl[12] = mk(1,1,1,0,0, 0,0,1);
    tbl[13] = mk(0,0,0,0,1, 0,0,1);
    tbl[14] = mk(1,0,0,0,0, 1,1,1);
    tbl[15] = mk(0,1,0,0,0, 0,0,1);
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].in_valid, tbl[i].out_ready, tbl[i].flush, tbl[i].mark, tbl[i].rewind, rand_row(8'(i)));
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_exp_level", i), level_o, tbl[i].exp_level);
      chk($sformatf("tbl%0d_exp_valid", i), out_valid_o, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_exp_ready", i), in_ready_o, tbl[i].exp_ready);
    end

    // Ramp row: slice k lane m must carry pixel value k+m
    for (int p = 0; p < RP; p++) ramp[p*BD +: BD] = 8'(p);
    set_in(1, 0, 0, 0, 0, ramp);
    tick("ramp");
    chk("ramp_level", level_o, 1);
    chk("ramp_valid", out_valid_o, 1);
    for (int m = 0; m < PIB; m++) exp_slice[m*BD +: BD] = 8'(m);
    chk_col("ramp_slice0", {{(COL_W-PIB*BD){1'b0}}, reference_input_column[0 +: PIB*BD]}, {{(COL_W-PIB*BD){1'b0}}, exp_slice});
    for (int m = 0; m < PIB; m++) exp_slice[m*BD +: BD] = 8'(7 + m);
    chk_col("ramp_slice7", {{(COL_W-PIB*BD){1'b0}}, reference_input_column[7*PIB*BD +: PIB*BD]}, {{(COL_W-PIB*BD){1'b0}}, exp_slice});
    set_in(0, 0, 1, 0, 0, '0);
    tick("flush_a");

    // Fill to capacity, then push+pop together: push refused
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 0, 0, 0, 0, rand_row(8'(i)));
      tick("fill");
    end
    chk("full_ready", in_ready_o, 0);
    chk("full_level", level_o, 16);
    set_in(1, 1, 0, 0, 0, rand_row(8'hEE));
    tick("full_pushpop");
    chk("full_pushpop_level", level_o, 15);
    set_in(0, 0, 1, 0, 0, '0);
    tick("flush_b");

    // Streaming across pointer wrap
    set_in(1, 0, 0, 0, 0, rand_row(8'd0));
    tick("stream_prime");
    for (int i = 0; i < 40; i++) begin
      set_in(1, 1, 0, 0, 0, rand_row(8'(i + 1)));
      tick("stream");
      chk("stream_level", level_o, 1);
      chk("stream_head_id", reference_input_column[7:0], (i + 1) & 8'hFF);
    end
    set_in(0, 0, 1, 0, 0, '0);
    tick("flush_c");

    // Mark at row 0, consume, refill to mark+DEPTH, then rewind and replay
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 0, 0, 0, rand_row(8'(i)));
      tick("mk_push");
    end
    set_in(0, 1, 0, 1, 0, '0);
    tick("mk_mark");
    for (int i = 0; i < 7; i++) begin
      set_in(0, 1, 0, 0, 0, '0);
      tick("mk_pop");
    end
    chk("mk_drained_level", level_o, 0);
    for (int i = 8; i < 16; i++) begin
      set_in(1, 0, 0, 0, 0, rand_row(8'(i)));
      tick("mk_refill");
    end
    chk("mk_full_past_mark", in_ready_o, 0);
    chk("mk_level_8", level_o, 8);
    set_in(1, 0, 0, 0, 0, rand_row(8'hAA));
    tick("mk_refused");
    chk("mk_refused_level", level_o, 8);
    set_in(0, 1, 0, 0, 1, '0);
    tick("mk_rewind");
    chk("mk_rewind_head", reference_input_column[7:0], 0);
    chk("mk_rewind_level", level_o, 16);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 0, 0, 0, '0);
      tick("mk_replay");
      chk("mk_replay_head", reference_input_column[7:0], i + 1);
    end
    set_in(0, 0, 1, 0, 0, '0);
    tick("flush_d");

    // Flush with 5 rows held and a mark set; later rewind must be inert
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, (i == 1), 0, rand_row(8'(i)));
      tick("fl_push");
    end
    set_in(1, 1, 1, 0, 0, rand_row(8'h55));
    tick("fl_flush");
    chk("fl_level", level_o, 0);
    chk("fl_valid", out_valid_o, 0);
    chk_col("fl_column_zero", reference_input_column, '0);
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 0, rand_row(8'(i + 20)));
      tick("fl_push2");
    end
    set_in(0, 1, 0, 0, 0, '0);
    tick("fl_pop");
    set_in(0, 0, 0, 0, 1, '0);
    tick("fl_rewind");
    chk("fl_rewind_inert_level", level_o, 1);
    chk("fl_rewind_inert_head", reference_input_column[7:0], 21);

    // Asynchronous reset between edges
    set_in(0, 0, 1, 0, 0, '0);
    tick("flush_e");
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, 0, 0, 0, rand_row(8'(i)));
      tick("ar_push");
    end
    set_in(0, 0, 0, 0, 0, '0);
    @(posedge clk_i);
    model_step();
    #3 rst_i = 1'b1;
    #1;
    model_reset();
    chk("ar_valid", out_valid_o, 0);
    chk("ar_level", level_o, 0);
    chk("ar_ready", in_ready_o, 1);
    chk_col("ar_column_zero", reference_input_column, '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    set_in(1, 0, 0, 0, 0, rand_row(8'h77));
    tick("ar_push_after");
    chk("ar_after_level", level_o, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
             $urandom_range(0, 99) < 6, rand_row(8'(i)));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
